// File: rtl/window_fetch.sv
// -----------------------------------------------------------------------------
// window_fetch
//
// Read-side sequencer for the median filter's image memory. For every centre
// pixel, in raster order, it reads the 3x3 neighbourhood. Neighbour rows and
// columns are clamped at the image borders and never wrap to an adjacent row.
// The nine returned samples are packed into a window, which is offered to the
// median core together with the centre-pixel address.
//
// Ports
//   iClk      clock, all logic on the rising edge
//   iRst      synchronous active-high reset, aborts a frame without oDone
//   iStart    one-cycle frame start pulse, honoured only when idle
//   oRd       read strobe towards the image memory
//   oRdAddr   read address, {row, col}, zero when oRd is low
//   iRdData   read data, valid one cycle after oRd
//   oWindow   nine samples, slot k at [k*DATA_W +: DATA_W]
//   oPixAddr  centre-pixel address {row, col}
//   oValid    oWindow / oPixAddr valid (PRESENT state)
//   iReady    downstream accepts the window
//   oBusy     a frame is in progress
//   oDone     one-cycle pulse once the last window has been accepted
// -----------------------------------------------------------------------------
module window_fetch #(
   parameter int WIDTH  = 128,
   parameter int HEIGHT = 64,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 13
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iStart,
   output logic                  oRd,
   output logic [ADDR_W-1:0]     oRdAddr,
   input  logic [DATA_W-1:0]     iRdData,
   output logic [9*DATA_W-1:0]   oWindow,
   output logic [ADDR_W-1:0]     oPixAddr,
   output logic                  oValid,
   input  logic                  iReady,
   output logic                  oBusy,
   output logic                  oDone
);

   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = ADDR_W - COL_W;
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_PRESENT,
      ST_DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [ROW_W-1:0]   row_reg, row_next;
   logic [COL_W-1:0]   col_reg, col_next;
   logic [3:0]         slot_reg, slot_next;
   logic [DATA_W-1:0]  slot_data_reg [9];

   logic [ROW_W-1:0]   row_nb;
   logic [COL_W-1:0]   col_nb;
   logic               last_pix;

   assign last_pix = (row_reg == ROW_MAX) && (col_reg == COL_MAX);

   // ---------------------------------------------------------------------
   // State and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_reg <= ST_IDLE;
         row_reg   <= '0;
         col_reg   <= '0;
         slot_reg  <= '0;
      end else begin
         state_reg <= state_next;
         row_reg   <= row_next;
         col_reg   <= col_next;
         slot_reg  <= slot_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      row_next   = row_reg;
      col_next   = col_reg;
      slot_next  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (iStart) begin
               state_next = ST_FETCH;
               row_next   = '0;
               col_next   = '0;
            end
         end
         ST_FETCH: begin
            if (slot_reg == 4'd8) begin
               state_next = ST_DRAIN;
            end else begin
               slot_next = slot_reg + 4'd1;
            end
         end
         ST_DRAIN: begin
            state_next = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (iReady) begin
               if (last_pix) begin
                  state_next = ST_DONE;
                  row_next   = '0;
                  col_next   = '0;
               end else begin
                  state_next = ST_FETCH;
                  if (col_reg == COL_MAX) begin
                     col_next = '0;
                     row_next = row_reg + 1'b1;
                  end else begin
                     col_next = col_reg + 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Neighbour address: slot k -> (dr, dc) = (k/3 - 1, k%3 - 1), each
   // coordinate clamped to the image so border pixels replicate.
   // ---------------------------------------------------------------------
   always_comb begin
      row_nb = row_reg;
      col_nb = col_reg;
      case (slot_reg)
         4'd0, 4'd1, 4'd2: if (row_reg != '0)     row_nb = row_reg - 1'b1;
         4'd6, 4'd7, 4'd8: if (row_reg != ROW_MAX) row_nb = row_reg + 1'b1;
         default: ;
      endcase
      case (slot_reg)
         4'd0, 4'd3, 4'd6: if (col_reg != '0)     col_nb = col_reg - 1'b1;
         4'd2, 4'd5, 4'd8: if (col_reg != COL_MAX) col_nb = col_reg + 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Sample capture. Data returns one cycle after its read, so slot k-1 is
   // written while slot k is being addressed; slot 8 lands during DRAIN.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < 9; gi++) begin : g_slot
      if (gi < 8) begin : g_fetch_slot
         always_ff @(posedge iClk) begin
            if (iRst) begin
               slot_data_reg[gi] <= '0;
            end else if (state_reg == ST_FETCH && slot_reg == 4'(gi + 1)) begin
               slot_data_reg[gi] <= iRdData;
            end
         end
      end else begin : g_drain_slot
         always_ff @(posedge iClk) begin
            if (iRst) begin
               slot_data_reg[gi] <= '0;
            end else if (state_reg == ST_DRAIN) begin
               slot_data_reg[gi] <= iRdData;
            end
         end
      end
      assign oWindow[gi*DATA_W +: DATA_W] = slot_data_reg[gi];
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign oRd      = (state_reg == ST_FETCH);
   assign oRdAddr  = oRd ? {row_nb, col_nb} : '0;
   assign oPixAddr = {row_reg, col_reg};
   assign oValid   = (state_reg == ST_PRESENT);
   assign oBusy    = (state_reg != ST_IDLE);
   assign oDone    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_window_fetch.sv
// -----------------------------------------------------------------------------
// tb_window_fetch
//
// Bench for window_fetch with a memory model mem[a] = a[7:0]. A negedge
// monitor pops expected read addresses, windows and centre addresses from a
// scoreboard; the next pixel's expectations are pushed at each handshake.
// Scenario tasks add literal-value and timing checks.
// -----------------------------------------------------------------------------
module tb_window_fetch;

   localparam int W   = 128;
   localparam int H   = 64;
   localparam int DW  = 8;
   localparam int AW  = 13;
   localparam int NPX = W * H;

   logic              iClk = 1'b0;
   logic              iRst;
   logic              iStart;
   logic              oRd;
   logic [AW-1:0]     oRdAddr;
   logic [DW-1:0]     iRdData;
   logic [9*DW-1:0]   oWindow;
   logic [AW-1:0]     oPixAddr;
   logic              oValid;
   logic              iReady;
   logic              oBusy;
   logic              oDone;

   int checks = 0;
   int errors = 0;

   int              exp_addr_q[$];
   logic [9*DW-1:0] exp_win_q[$];
   int              exp_pix_q[$];
   int              mon_pix = 0;
   bit              seen_valid = 1'b0;
   int              hs_count = 0;

   window_fetch #(
      .WIDTH  (W),
      .HEIGHT (H),
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iStart   (iStart),
      .oRd      (oRd),
      .oRdAddr  (oRdAddr),
      .iRdData  (iRdData),
      .oWindow  (oWindow),
      .oPixAddr (oPixAddr),
      .oValid   (oValid),
      .iReady   (iReady),
      .oBusy    (oBusy),
      .oDone    (oDone)
   );

   always #5 iClk = ~iClk;

   // Image memory: one-cycle read latency, content = low byte of address.
   always @(posedge iClk) begin
      iRdData <= oRd ? oRdAddr[7:0] : 8'hA5;
   end

   // Expected reads and window for centre pixel p.
   function automatic void push_pixel(input int p);
      int r, c, rr, cc, a;
      logic [9*DW-1:0] win;
      r = p / W;
      c = p % W;
      win = '0;
      for (int k = 0; k < 9; k++) begin
         rr = r + k / 3 - 1;
         cc = c + k % 3 - 1;
         if (rr < 0) rr = 0;
         if (rr > H - 1) rr = H - 1;
         if (cc < 0) cc = 0;
         if (cc > W - 1) cc = W - 1;
         a = rr * W + cc;
         exp_addr_q.push_back(a);
         win[k*DW +: DW] = DW'(a % 256);
      end
      exp_win_q.push_back(win);
      exp_pix_q.push_back(p);
   endfunction

   // Scoreboard monitor.
   always @(negedge iClk) begin
      int ea, ep;
      logic [9*DW-1:0] ew;
      if (iRst) begin
         exp_addr_q.delete();
         exp_win_q.delete();
         exp_pix_q.delete();
         seen_valid = 1'b0;
      end else begin
         if (oRd) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
               errors++;
               $display("FAIL sb_rd_unexpected got=%0d required=no read", oRdAddr);
            end else begin
               ea = exp_addr_q.pop_front();
               if (oRdAddr !== AW'(ea)) begin
                  errors++;
                  $display("FAIL sb_rd_addr got=%0d required=%0d", oRdAddr, ea);
               end
            end
         end
         if (oValid && !seen_valid) begin
            seen_valid = 1'b1;
            checks++;
            if (exp_win_q.size() == 0 || exp_pix_q.size() == 0) begin
               errors++;
               $display("FAIL sb_valid_unexpected pix=%0d required=no window", oPixAddr);
            end else begin
               ew = exp_win_q.pop_front();
               ep = exp_pix_q.pop_front();
               mon_pix = ep;
               if (oWindow !== ew || oPixAddr !== AW'(ep)) begin
                  errors++;
                  $display("FAIL sb_window pix=%0d win=%h required pix=%0d win=%h",
                           oPixAddr, oWindow, ep, ew);
               end
            end
         end
         if (oValid && iReady) begin
            hs_count++;
            seen_valid = 1'b0;
            if (mon_pix < NPX - 1) push_pixel(mon_pix + 1);
         end
      end
   end

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic start_frame();
      push_pixel(0);
      iStart = 1'b1;
      step();
      iStart = 1'b0;
   endtask

   task automatic test_reset();
      iRst   = 1'b1;
      iStart = 1'b0;
      iReady = 1'b1;
      repeat (3) step();
      checks++; if (oRd !== 1'b0)      begin errors++; $display("FAIL reset_rd got=%b required=0", oRd); end
      checks++; if (oValid !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b required=0", oValid); end
      checks++; if (oBusy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b required=0", oBusy); end
      checks++; if (oDone !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b required=0", oDone); end
      checks++; if (oRdAddr !== '0)    begin errors++; $display("FAIL reset_rdaddr got=%0d required=0", oRdAddr); end
      checks++; if (oPixAddr !== '0)   begin errors++; $display("FAIL reset_pixaddr got=%0d required=0", oPixAddr); end
      checks++; if (oWindow !== '0)    begin errors++; $display("FAIL reset_window got=%h required=0", oWindow); end
      iRst = 1'b0;
      repeat (2) step();
      checks++; if (oBusy !== 1'b0 || oRd !== 1'b0) begin
         errors++; $display("FAIL idle_no_start busy=%b rd=%b required 0 0", oBusy, oRd);
      end
      $display("test_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   // First pixel, 20-cycle stall, release timing, then reset in FETCH of pixel 300.
   task automatic test_backpressure_abort();
      int tbl0[9] = '{0, 0, 1, 0, 0, 1, 128, 128, 129};
      logic [9*DW-1:0] hold_win;
      iReady = 1'b0;
      start_frame();                                   // now cycle 1
      checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL busy_rise got=%b required=1", oBusy); end
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (oRd !== 1'b1 || oRdAddr !== AW'(tbl0[k])) begin
            errors++; $display("FAIL first_addr k=%0d rd=%b got=%0d required=%0d", k, oRd, oRdAddr, tbl0[k]);
         end
         step();
      end                                              // cycle 10: DRAIN
      checks++; if (oValid !== 1'b0 || oRd !== 1'b0) begin
         errors++; $display("FAIL drain valid=%b rd=%b required 0 0", oValid, oRd);
      end
      step();                                          // cycle 11: PRESENT
      checks++; if (oValid !== 1'b1 || oPixAddr !== '0) begin
         errors++; $display("FAIL first_valid valid=%b pix=%0d required 1 0", oValid, oPixAddr);
      end
      hold_win = oWindow;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (oValid !== 1'b1 || oRd !== 1'b0 || oPixAddr !== '0 || oWindow !== hold_win) begin
            errors++; $display("FAIL stall_hold i=%0d valid=%b rd=%b pix=%0d win=%h required 1 0 0 %h",
                               i, oValid, oRd, oPixAddr, oWindow, hold_win);
         end
         step();
      end                                              // cycle 31
      iReady = 1'b1;                                   // accepted at end of cycle 31
      repeat (10) step();                              // cycle 41
      checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL release_early got=%b required=0", oValid); end
      step();                                          // cycle 42
      checks++; if (oValid !== 1'b1 || oPixAddr !== AW'(1)) begin
         errors++; $display("FAIL release_next valid=%b pix=%0d required 1 1", oValid, oPixAddr);
      end
      repeat (3323 - 42) step();                       // pixel 300, FETCH k=2
      checks++; if (oRd !== 1'b1 || oPixAddr !== AW'(300)) begin
         errors++; $display("FAIL pre_abort rd=%b pix=%0d required 1 300", oRd, oPixAddr);
      end
      iRst = 1'b1;
      step();
      checks++;
      if (oRd !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0 ||
          oRdAddr !== '0 || oPixAddr !== '0 || oWindow !== '0) begin
         errors++; $display("FAIL abort_outputs rd=%b valid=%b busy=%b done=%b rdaddr=%0d pix=%0d win=%h required all 0",
                            oRd, oValid, oBusy, oDone, oRdAddr, oPixAddr, oWindow);
      end
      iRst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (oDone !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL abort_quiet i=%0d done=%b busy=%b required 0 0", i, oDone, oBusy);
         end
      end
      $display("test_backpressure_abort done checks=%0d errors=%0d", checks, errors);
   endtask

   // Whole frame with iReady high, restart after the abort, stray iStart mid-frame.
   task automatic test_full_frame();
      int tbl0[9]    = '{0, 0, 1, 0, 0, 1, 128, 128, 129};
      int tbl129[9]  = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
      int tbl8191[9] = '{8062, 8063, 8063, 8190, 8191, 8191, 8190, 8191, 8191};
      logic [9*DW-1:0] win129;
      int done_cnt, done_cyc, k;
      win129   = {8'h02, 8'h01, 8'h00, 8'h82, 8'h81, 8'h80, 8'h02, 8'h01, 8'h00};
      done_cnt = 0;
      done_cyc = -1;
      iReady   = 1'b1;
      hs_count = 0;
      start_frame();
      for (int cyc = 1; cyc <= 90116; cyc++) begin
         if (cyc <= 9) begin
            checks++;
            if (oRdAddr !== AW'(tbl0[cyc-1])) begin
               errors++; $display("FAIL restart_addr k=%0d got=%0d required=%0d", cyc - 1, oRdAddr, tbl0[cyc-1]);
            end
         end
         if (cyc >= 1 + 11*129 && cyc <= 9 + 11*129) begin
            k = cyc - 1 - 11*129;
            checks++;
            if (oRd !== 1'b1 || oRdAddr !== AW'(tbl129[k])) begin
               errors++; $display("FAIL p129_addr k=%0d got=%0d required=%0d", k, oRdAddr, tbl129[k]);
            end
         end
         if (cyc == 11 + 11*129) begin
            checks++;
            if (oValid !== 1'b1 || oPixAddr !== AW'(129) || oWindow !== win129) begin
               errors++; $display("FAIL p129_window valid=%b pix=%0d win=%h required 1 129 %h",
                                  oValid, oPixAddr, oWindow, win129);
            end
         end
         if (cyc >= 1 + 11*8191 && cyc <= 9 + 11*8191) begin
            k = cyc - 1 - 11*8191;
            checks++;
            if (oRd !== 1'b1 || oRdAddr !== AW'(tbl8191[k])) begin
               errors++; $display("FAIL p8191_addr k=%0d got=%0d required=%0d", k, oRdAddr, tbl8191[k]);
            end
         end
         if (cyc == 11 + 11*8191) begin
            checks++;
            if (oValid !== 1'b1 || oPixAddr !== AW'(8191)) begin
               errors++; $display("FAIL p8191_valid valid=%b pix=%0d required 1 8191", oValid, oPixAddr);
            end
         end
         if (cyc == 500) iStart = 1'b1;
         if (cyc == 501) iStart = 1'b0;
         if (oDone === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cyc == 90114) begin
            checks++;
            if (oBusy !== 1'b0 || oRd !== 1'b0 || oValid !== 1'b0) begin
               errors++; $display("FAIL post_done busy=%b rd=%b valid=%b required 0 0 0", oBusy, oRd, oValid);
            end
         end
         step();
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_pulses got=%0d required=1", done_cnt); end
      checks++; if (done_cyc != 90113) begin errors++; $display("FAIL done_cycle got=%0d required=90113", done_cyc); end
      checks++; if (hs_count != NPX) begin errors++; $display("FAIL handshakes got=%0d required=%0d", hs_count, NPX); end
      checks++;
      if (exp_addr_q.size() != 0 || exp_win_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover addr=%0d win=%0d required 0 0", exp_addr_q.size(), exp_win_q.size());
      end
      $display("test_full_frame done checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      iRst   = 1'b1;
      iStart = 1'b0;
      iReady = 1'b1;
      test_reset();
      test_backpressure_abort();
      test_full_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_fetch.md
Name: window_fetch

Overview:
- Read-side sequencer for the image memory used by the median filter.
- For each centre pixel, in raster order, it issues the 9 read addresses of the 3x3 neighbourhood. Neighbours are clamped at the image borders.
- It collects the returned samples into a packed window and hands the window to the median core with a valid/ready handshake.
- It also outputs the centre-pixel address, which the output writer uses as its write address. One pixel takes a minimum of 11 cycles, matching the writer's 11-cycle cadence.

Parameters:
- WIDTH, 128, image width in pixels; must be a power of two.
- HEIGHT, 64, image height in pixels.
- DATA_W, 8, pixel width in bits.
- ADDR_W, 13, memory address width; log2(WIDTH*HEIGHT).

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse that starts a frame; ignored while oBusy=1.
- oRd  out  1  read strobe for the image memory.
- oRdAddr  out  ADDR_W  read address; meaningful only when oRd=1.
- iRdData  in  DATA_W  read data; valid exactly 1 cycle after oRd.
- oWindow  out  9*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W].
- oPixAddr  out  ADDR_W  address of the current centre pixel.
- oValid  out  1  oWindow and oPixAddr are valid.
- iReady  in  1  downstream accepts the window.
- oBusy  out  1  high from the cycle after iStart is accepted until oDone.
- oDone  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: state=IDLE.
  - oRd, oValid, oBusy, oDone = 0.
  - oRdAddr, oPixAddr, row/col counters, slot counter = 0.
  - oWindow = 0.
  - Reset mid-frame aborts immediately; no oDone is produced.
- States: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE -> FETCH when iStart=1.
  - Row and col are cleared to 0 on entry.
  - oBusy=1 from the next cycle.
- FETCH lasts exactly 9 cycles, with k=0..8.
  - Each cycle drives oRd=1 and oRdAddr = clamp_row(r+dr)*WIDTH + clamp_col(c+dc), where dr=k/3-1 and dc=k%3-1.
  - clamp_row limits to [0,HEIGHT-1]; clamp_col limits to [0,WIDTH-1]. No wrap to the adjacent row.
  - Address is formed by concatenation {row,col}.
  - Each cycle with k>=1 captures iRdData into slot k-1.
  - After k=8 -> DRAIN.
- DRAIN: 1 cycle.
  - oRd=0; captures iRdData into slot 8.
  - -> PRESENT.
- PRESENT: oValid=1.
  - oWindow and oPixAddr = r*WIDTH+c are held stable until iReady=1.
  - On oValid&&iReady, the pixel advances: c+1; when c=WIDTH-1, c=0 and r+1.
  - If that was the last pixel (r=HEIGHT-1, c=WIDTH-1) -> DONE; otherwise -> FETCH.
- DONE: 1 cycle.
  - oDone=1, oBusy=0 on the following cycle.
  - -> IDLE.
- Throughput: with iReady held high, one window every 11 cycles (9 FETCH + 1 DRAIN + 1 PRESENT). A full 128x64 frame takes 90112 cycles plus 1 DONE cycle.
- Backpressure: oRd stays low in PRESENT; no reads are issued while stalled.
- iStart arriving during oBusy or DONE has no effect.
- oWindow keeps its last value outside PRESENT. Slots are overwritten progressively during FETCH/DRAIN.

Test Plan:
- Reset, then iStart with iReady=1; record the first 9 oRdAddr values.
  - Required: 0,0,1,0,0,1,128,128,129.
  - oValid rises 10 cycles after FETCH entry; oPixAddr=0.
- Memory model mem[a]=a[7:0]. Centre pixel 129 (r1,c1):
  - Required addresses: 0,1,2,128,129,130,256,257,258.
  - oWindow slots, low to high: 0x00,0x01,0x02,0x80,0x81,0x82,0x00,0x01,0x02.
- Last pixel 8191 (r63,c127):
  - Required addresses: 8062,8063,8063,8190,8191,8191,8190,8191,8191.
  - After acceptance: oDone pulses once; oBusy falls; state returns to IDLE.
- Hold iReady=0 for 20 cycles in PRESENT:
  - oValid, oWindow and oPixAddr stay constant; oRd=0 throughout.
  - Releasing iReady advances to oPixAddr+1 11 cycles after acceptance.
- Full frame with iReady=1:
  - Exactly 8192 handshakes with oPixAddr 0..8191 in order.
  - oDone at cycle 90113 after start.
  - A second iStart pulse mid-frame is ignored.
- Assert iRst during FETCH of pixel 300:
  - Next cycle: all outputs 0, no oDone.
  - A subsequent iStart restarts at pixel 0 with addresses 0,0,1,...
